// File: rtl/enc_stage_2_out_buf.sv
// enc_stage_2_out_buf
// Masks the encoder codeword to the active length of the work mode, optionally
// injects a masked noise vector, and holds the result in a 2-entry FIFO that is
// drained through a valid/ready handshake. It also reports the bit flips for
// each word and keeps a wrapping count of accepted words.
//
// Optional feature macro: ENC_STAGE2_NOISE_EN
//   defined   : stored word = (data_in ^ noise) & mask, out_flips = popcount(noise & mask)
//   undefined : noise ignored, stored word = data_in & mask, out_flips = 0
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   data_in/work_mod/noise valid
//   in_ready   out  buffer can accept a word (registered)
//   data_in    in   codeword from the encoder stage
//   work_mod   in   0 = len 8, 1 = len 16, 2 = len 32
//   noise      in   error vector to inject
//   out_valid  out  data_out holds a valid word (registered)
//   out_ready  in   consumer accepts data_out
//   data_out   out  head entry: noisy codeword
//   out_flips  out  head entry: number of flipped bits
//   out_err    out  head entry: accepted with an illegal work_mod
//   word_cnt   out  accepted word count, wraps
module enc_stage_2_out_buf #(
  parameter int unsigned AMBA_WORD          = 32,
  parameter int unsigned MAX_CODEWORD_WIDTH = 32,
  parameter int unsigned CNT_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
  input  logic [AMBA_WORD-1:0]          work_mod,
  input  logic [MAX_CODEWORD_WIDTH-1:0] noise,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
  output logic [5:0]                    out_flips,
  output logic                          out_err,
  output logic [CNT_WIDTH-1:0]          word_cnt
);

  localparam int unsigned FLIPS_W = 6;
  localparam int unsigned CW      = MAX_CODEWORD_WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_in_ready;
  logic              r_out_valid;
  logic [CW-1:0]     r_head_data;
  logic [FLIPS_W-1:0] r_head_flips;
  logic              r_head_err;
  logic [CW-1:0]     r_tail_data;
  logic [FLIPS_W-1:0] r_tail_flips;
  logic              r_tail_err;
  logic [CNT_WIDTH-1:0] r_word_cnt;

  logic              w_push;
  logic              w_pop;
  int unsigned       w_len;
  logic              w_legal;
  logic [CW-1:0]     w_mask;
  logic [CW-1:0]     w_word;
  logic [FLIPS_W-1:0] w_flips;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;

  // Active length from the work mode; a length wider than the codeword is illegal.
  always_comb begin
    w_len   = 0;
    w_legal = 1'b0;
    w_mask  = '0;
    if (work_mod == AMBA_WORD'(0))      w_len = 8;
    else if (work_mod == AMBA_WORD'(1)) w_len = 16;
    else if (work_mod == AMBA_WORD'(2)) w_len = 32;
    w_legal = (w_len != 0) && (w_len <= CW);
    for (int unsigned i = 0; i < CW; i++) begin
      w_mask[i] = w_legal && (i < w_len);
    end
  end

`ifdef ENC_STAGE2_NOISE_EN
  logic [CW-1:0] w_noise_m;

  function automatic logic [FLIPS_W-1:0] popcount(input logic [CW-1:0] v);
    logic [FLIPS_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < CW; i++) begin
      c = c + FLIPS_W'(v[i]);
    end
    return c;
  endfunction

  assign w_noise_m = noise & w_mask;
  assign w_word    = (data_in & w_mask) ^ w_noise_m;
  assign w_flips   = popcount(w_noise_m);
`else
  logic w_unused_noise;

  assign w_unused_noise = ^noise;
  assign w_word         = data_in & w_mask;
  assign w_flips        = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_EMPTY;
    else      r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
      ST_ONE: begin
        if (w_push && !w_pop)      w_state_nxt = ST_FULL;
        else if (w_pop && !w_push) w_state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (w_pop) w_state_nxt = ST_ONE;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Handshake flags registered from the next state so they never see out_ready combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  // Storage: head drives the outputs directly, tail holds the second word when full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head_data  <= '0;
      r_head_flips <= '0;
      r_head_err   <= 1'b0;
      r_tail_data  <= '0;
      r_tail_flips <= '0;
      r_tail_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            r_head_data  <= w_word;
            r_head_flips <= w_flips;
            r_head_err   <= ~w_legal;
          end
        end
        ST_ONE: begin
          // Simultaneous push and pop replaces the head; push alone fills the tail.
          if (w_push && w_pop) begin
            r_head_data  <= w_word;
            r_head_flips <= w_flips;
            r_head_err   <= ~w_legal;
          end else if (w_push) begin
            r_tail_data  <= w_word;
            r_tail_flips <= w_flips;
            r_tail_err   <= ~w_legal;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            r_head_data  <= r_tail_data;
            r_head_flips <= r_tail_flips;
            r_head_err   <= r_tail_err;
          end
        end
        default: ;
      endcase
    end
  end

  // Accepted-word counter, wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_word_cnt <= '0;
    else if (w_push) r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign data_out  = r_head_data;
  assign out_flips = r_head_flips;
  assign out_err   = r_head_err;
  assign word_cnt  = r_word_cnt;

endmodule
